bank_serial_sender: RTL
=======================

Name: bank_serial_sender

Overview:
- Downstream readout stage of the spectrogram acquisition core.
- When the acquisition side declares a memory bank full, the block waits for a host readout request.
- It then reads each stored event from the read bank: a timestamp and a 7-bit channel value.
- It shifts each event out MSB-first on serial_out, with SL_time/SL_ch framing strobes, then releases the bank and toggles read_bank.

Parameters:
- TS_W, 16, timestamp width in bits (RTC count stored per event)
- CH_W, 7, channel sample width in bits (ch1 value)
- DEPTH, 16, entries per bank
- ADDR_W, 4, entry address width; DEPTH = 2**ADDR_W

Ports:
- input_serial_readout_clk  in  1  sole clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- bank_full  in  1  level, already synchronised to this clock; a bank holds entry_count valid events
- entry_count  in  ADDR_W+1  number of valid events in the full bank, 0..DEPTH
- serial_readout  in  1  host request level; sampled only in PENDING
- mem_rd_en  out  1  read strobe to bank memory
- mem_addr  out  ADDR_W  entry index
- mem_bank  out  1  bank select, equal to read_bank
- mem_data  in  TS_W+CH_W  {timestamp, channel}, valid exactly 1 cycle after mem_rd_en
- serial_out  out  1  serial data, MSB first
- SL_time  out  1  high while timestamp bits are on serial_out
- SL_ch  out  1  high while channel bits are on serial_out
- sending_pending  out  1  bank full, waiting for host
- sending_started  out  1  one-cycle pulse on transfer start
- sending_data  out  1  high from transfer start to release
- bank_released  out  1  one-cycle pulse; acquisition may reuse the bank
- read_bank  out  1  current read bank index
- state_reg_FSM  out  3  current state encoding, for debug

Behaviour:
- Reset values: all outputs 0; read_bank=0; state IDLE; entry index 0.
- All outputs are registered.
- State encodings:
  - IDLE=0: if bank_full -> PENDING.
  - PENDING=1: sending_pending=1. When serial_readout=1 -> FETCH, with a sending_started pulse in the same transition cycle.
  - PENDING with entry_count==0 and serial_readout=1 -> RELEASE. sending_started still pulses.
  - FETCH=2: mem_rd_en=1, mem_addr=idx; -> LOAD.
  - LOAD=3: capture mem_data into the shift register; -> SHIFT_TS.
  - SHIFT_TS=4: TS_W cycles, serial_out=timestamp MSB first, SL_time=1; -> SHIFT_CH.
  - SHIFT_CH=5: CH_W cycles, serial_out=channel MSB first, SL_ch=1; -> NEXT.
  - NEXT=6: if idx==count-1 -> RELEASE, else idx+1 and -> FETCH.
  - RELEASE=7: bank_released=1 for one cycle, read_bank toggles, idx=0; -> IDLE.
- SL_time and SL_ch are never high together. serial_out=0 whenever neither is high.
- sending_data=1 in states FETCH..RELEASE inclusive.
- Per-entry cost: 2 + TS_W + CH_W + 1 cycles (26 with defaults). Between entries there are 3 idle serial cycles (NEXT, FETCH, LOAD).
- entry_count is latched on the PENDING->FETCH transition. Values above DEPTH are clamped to DEPTH.
- Deassertion of serial_readout after the start is ignored; the transfer always completes.
- bank_full is ignored outside IDLE. If bank_full is still high in IDLE after a release, a new PENDING begins on the next cycle.
- Reset mid-transfer: outputs return to reset values asynchronously. No bank_released pulse is emitted, and read_bank returns to 0.

Decomposition:
- Shared package (spectro_pkg): TS_W, CH_W, DEPTH, ADDR_W constants, and the 3-bit state enum (IDLE..RELEASE) so top-level debug decoding matches.
- One natural sub-module: piso_shift. It is a loadable parallel-in/serial-out register with a bit counter and a done flag, reused for the timestamp and channel phases.

Test Plan:
- Reset then idle: bank_full=0 for 50 cycles -> all outputs 0, state_reg_FSM=0.
- Single event: bank_full=1, entry_count=1, mem_data={16'hA5C3,7'h55}, serial_readout=1 after 10 cycles:
  - sending_started pulses once.
  - serial_out carries 1010010111000011 under SL_time, then 1010101 under SL_ch.
  - bank_released pulses on cycle 26 after start; read_bank goes 0->1.
- Full bank: entry_count=16 with mem_data = address-derived pattern -> 16 frames in address order 0..15, 26 cycles each, exactly 16 mem_rd_en pulses.
- Empty bank: entry_count=0, serial_readout=1 -> no mem_rd_en, no SL strobes; sending_started and bank_released pulse; read_bank toggles.
- Host gating: bank_full=1, serial_readout=0 for 100 cycles -> sending_pending=1 throughout, mem_rd_en never asserts.
  - Then serial_readout pulses high 1 cycle and drops -> full transfer completes.
- Reset mid-shift: assert reset during SHIFT_TS of entry 3 -> same cycle all outputs 0, read_bank=0, no bank_released.
  - After release of reset with bank_full=1 -> PENDING again.

Source files
------------

// File: rtl/spectro_pkg.sv
// Shared constants and state encoding for the spectrogram readout path.
package spectro_pkg;
   localparam int unsigned TS_W     = 16;
   localparam int unsigned CH_W     = 7;
   localparam int unsigned DEPTH    = 16;
   localparam int unsigned ADDR_W   = 4;
   localparam int unsigned MEM_W    = TS_W + CH_W;
   localparam int unsigned BITCNT_W = $clog2(TS_W + 1);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PENDING  = 3'd1,
      FETCH    = 3'd2,
      LOAD     = 3'd3,
      SHIFT_TS = 3'd4,
      SHIFT_CH = 3'd5,
      NEXT     = 3'd6,
      RELEASE  = 3'd7
   } state_e;

   function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
      return (c > DEPTH_CNT) ? DEPTH_CNT : c;
   endfunction
endpackage

// File: rtl/piso_shift.sv
// Loadable parallel-in/serial-out register, MSB first, with a remaining-bit
// counter; done_o marks the cycle in which the last bit is presented.
module piso_shift #(
   parameter int unsigned W     = 16,
   parameter int unsigned CNT_W = $clog2(W + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [W-1:0]     data_i,
   input  logic [CNT_W-1:0] len_i,
   output logic             ser_o,
   output logic             done_o
);
   logic [W-1:0]     sh_q, sh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ser_q, ser_d;

   // ser_q holds the bit currently on the line; sh_q holds the bits still queued.
   always_comb begin
      sh_d  = sh_q;
      cnt_d = cnt_q;
      ser_d = ser_q;
      if (load_i) begin
         ser_d = data_i[W-1];
         sh_d  = {data_i[W-2:0], 1'b0};
         cnt_d = len_i;
      end else if (cnt_q > CNT_W'(1)) begin
         ser_d = sh_q[W-1];
         sh_d  = {sh_q[W-2:0], 1'b0};
         cnt_d = cnt_q - CNT_W'(1);
      end else if (cnt_q == CNT_W'(1)) begin
         ser_d = 1'b0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sh_q  <= '0;
         cnt_q <= '0;
         ser_q <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
         ser_q <= ser_d;
      end
   end

   assign ser_o  = ser_q;
   assign done_o = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/bank_serial_sender.sv
// Bank readout stage: waits for host request on a full bank, serialises each
// {timestamp, channel} event MSB first with framing strobes, then releases the bank.
module bank_serial_sender
   import spectro_pkg::*;
(
   input  logic              input_serial_readout_clk,
   input  logic              reset,
   input  logic              bank_full,
   input  logic [ADDR_W:0]   entry_count,
   input  logic              serial_readout,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_bank,
   input  logic [MEM_W-1:0]  mem_data,
   output logic              serial_out,
   output logic              SL_time,
   output logic              SL_ch,
   output logic              sending_pending,
   output logic              sending_started,
   output logic              sending_data,
   output logic              bank_released,
   output logic              read_bank,
   output logic [2:0]        state_reg_FSM
);
   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic                rd_q, rd_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                slt_q, slt_d;
   logic                slc_q, slc_d;
   logic                pend_q, pend_d;
   logic                start_q, start_d;
   logic                busy_q, busy_d;
   logic                rel_q, rel_d;
   logic                rb_q, rb_d;

   logic                piso_load;
   logic [TS_W-1:0]     piso_data;
   logic [BITCNT_W-1:0] piso_len;
   logic                piso_ser;
   logic                piso_done;

   piso_shift #(.W(TS_W), .CNT_W(BITCNT_W)) u_piso (
      .clk_i  (input_serial_readout_clk),
      .rst_i  (reset),
      .load_i (piso_load),
      .data_i (piso_data),
      .len_i  (piso_len),
      .ser_o  (piso_ser),
      .done_o (piso_done)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      count_d   = count_q;
      ch_d      = ch_q;
      piso_load = 1'b0;
      piso_data = mem_data[MEM_W-1 -: TS_W];
      piso_len  = BITCNT_W'(TS_W);
      case (state_q)
         IDLE:     if (bank_full) state_d = PENDING;
         PENDING:  if (serial_readout) begin
                      count_d = clamp_count(entry_count);
                      idx_d   = '0;
                      state_d = (count_d == '0) ? RELEASE : FETCH;
                   end
         FETCH:    state_d = LOAD;
         LOAD: begin
            piso_load = 1'b1;
            ch_d      = mem_data[CH_W-1:0];
            state_d   = SHIFT_TS;
         end
         // Channel bits are reloaded left-aligned on the last timestamp bit so the
         // two phases run back to back with no gap on serial_out.
         SHIFT_TS: if (piso_done) begin
                      piso_load = 1'b1;
                      piso_data = {ch_q, {(TS_W - CH_W){1'b0}}};
                      piso_len  = BITCNT_W'(CH_W);
                      state_d   = SHIFT_CH;
                   end
         SHIFT_CH: if (piso_done) state_d = NEXT;
         NEXT: begin
            if (({1'b0, idx_q} + (ADDR_W + 1)'(1)) == count_q) begin
               state_d = RELEASE;
            end else begin
               idx_d   = idx_q + ADDR_W'(1);
               state_d = FETCH;
            end
         end
         RELEASE: begin
            idx_d   = '0;
            state_d = IDLE;
         end
         default:  state_d = IDLE;
      endcase

      // Outputs are registered against the state being entered.
      rd_d    = (state_d == FETCH);
      addr_d  = rd_d ? idx_d : '0;
      slt_d   = (state_d == SHIFT_TS);
      slc_d   = (state_d == SHIFT_CH);
      pend_d  = (state_d == PENDING);
      start_d = (state_q == PENDING) && (state_d != PENDING);
      busy_d  = (state_d != IDLE) && (state_d != PENDING);
      rel_d   = (state_d == RELEASE) && (state_q != RELEASE);
      rb_d    = rel_d ? ~rb_q : rb_q;
   end

   always_ff @(posedge input_serial_readout_clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         count_q <= '0;
         ch_q    <= '0;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         slt_q   <= 1'b0;
         slc_q   <= 1'b0;
         pend_q  <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         rel_q   <= 1'b0;
         rb_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         ch_q    <= ch_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         slt_q   <= slt_d;
         slc_q   <= slc_d;
         pend_q  <= pend_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         rel_q   <= rel_d;
         rb_q    <= rb_d;
      end
   end

   assign mem_rd_en       = rd_q;
   assign mem_addr        = addr_q;
   assign mem_bank        = rb_q;
   assign serial_out      = piso_ser;
   assign SL_time         = slt_q;
   assign SL_ch           = slc_q;
   assign sending_pending = pend_q;
   assign sending_started = start_q;
   assign sending_data    = busy_q;
   assign bank_released   = rel_q;
   assign read_bank       = rb_q;
   assign state_reg_FSM   = state_q;
endmodule
